// File: rtl/knn_pkg.sv
// Shared constants, element typedef and serving FSM states
// used by the kNN training data server.
package knn_pkg;

    localparam int M            = 4;
    localparam int N            = 4;
    localparam int W            = 8;
    localparam int MAX_ELEMENTS = 16;
    localparam int TYPE_W       = 2;
    localparam int ADDR_W       = 4;
    localparam int ELEM_W       = W * M * N;

    typedef logic [ELEM_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REQ,
        FETCH,
        DONE
    } state_e;

    function automatic logic [W-1:0] elem_entry(
        input elem_t e,
        input int    r,
        input int    c
    );
        return e[(r*N+c)*W +: W];
    endfunction

endpackage

// File: rtl/training_mem.sv
// Simple dual-port training memory: synchronous write,
// registered one-cycle read. Contents are never reset.
module training_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 130,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic          wr_ok;

    assign wr_ok     = wr_en_i &&
                       ({1'b0, wr_addr_i} < (AW+1)'(DEPTH));
    assign rd_data_o = rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/training_data_server.sv
// Serves one stored training element per data_request edge
// to the kNN distance calculator; host loads memory and query.
module training_data_server
    import knn_pkg::*;
#(
    parameter int M            = knn_pkg::M,
    parameter int N            = knn_pkg::N,
    parameter int W            = knn_pkg::W,
    parameter int MAX_ELEMENTS = knn_pkg::MAX_ELEMENTS,
    parameter int TYPE_W       = knn_pkg::TYPE_W,
    parameter int ADDR_W       = knn_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_we,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [W*M*N-1:0]    load_data,
    input  logic [TYPE_W-1:0]   load_type,
    input  logic                load_input_we,
    input  logic                start,
    input  logic                data_request,
    output logic [W*M*N-1:0]    training_data,
    output logic [TYPE_W-1:0]   training_data_type,
    output logic [W*M*N-1:0]    input_data,
    output logic                read_done,
    output logic [ADDR_W-1:0]   elem_index,
    output logic                busy,
    output logic                pass_done
);

    localparam int EW = W * M * N;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ELEMENTS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                req_q;
    logic [EW-1:0]       td_q, td_d;
    logic [TYPE_W-1:0]   tt_q, tt_d;
    logic [EW-1:0]       in_q, in_d;
    logic                rdone_q, rdone_d;
    logic [ADDR_W-1:0]   eidx_q, eidx_d;
    logic                busy_q, busy_d;
    logic                pdone_q, pdone_d;
    logic                rd_en;
    logic                req_edge;
    logic [EW+TYPE_W-1:0] mem_rdata;

    assign req_edge = data_request & ~req_q;

    training_mem #(
        .DEPTH (MAX_ELEMENTS),
        .DW    (EW + TYPE_W),
        .AW    (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (load_we & ~busy_q),
        .wr_addr_i (load_addr),
        .wr_data_i ({load_data, load_type}),
        .rd_en_i   (rd_en),
        .rd_addr_i (idx_q),
        .rd_data_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        td_d    = td_q;
        tt_d    = tt_q;
        eidx_d  = eidx_q;
        busy_d  = busy_q;
        rdone_d = 1'b0;
        pdone_d = 1'b0;
        rd_en   = 1'b0;
        in_d    = (load_input_we && !busy_q) ? load_data : in_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_REQ;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            WAIT_REQ: begin
                if (req_edge) begin
                    rd_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                {td_d, tt_d} = mem_rdata;
                eidx_d  = idx_q;
                rdone_d = 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = WAIT_REQ;
                end
            end
            DONE: begin
                pdone_d = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            req_q   <= 1'b0;
            td_q    <= '0;
            tt_q    <= '0;
            in_q    <= '0;
            rdone_q <= 1'b0;
            eidx_q  <= '0;
            busy_q  <= 1'b0;
            pdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            req_q   <= data_request;
            td_q    <= td_d;
            tt_q    <= tt_d;
            in_q    <= in_d;
            rdone_q <= rdone_d;
            eidx_q  <= eidx_d;
            busy_q  <= busy_d;
            pdone_q <= pdone_d;
        end
    end

    assign training_data      = td_q;
    assign training_data_type = tt_q;
    assign input_data         = in_q;
    assign read_done          = rdone_q;
    assign elem_index         = eidx_q;
    assign busy               = busy_q;
    assign pass_done          = pdone_q;

endmodule

// File: tb/tb_training_data_server.sv
// Directed bench for training_data_server: reset, full passes,
// held requests, blocked loads, mid-pass reset, query register.
module tb_training_data_server;

    localparam int EW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_we = 1'b0;
    logic [3:0]    load_addr = '0;
    logic [EW-1:0] load_data = '0;
    logic [1:0]    load_type = '0;
    logic          load_input_we = 1'b0;
    logic          start = 1'b0;
    logic          data_request = 1'b0;
    logic [EW-1:0] training_data;
    logic [1:0]    training_data_type;
    logic [EW-1:0] input_data;
    logic          read_done;
    logic [3:0]    elem_index;
    logic          busy;
    logic          pass_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [EW-1:0] exp_d [16];
    logic [1:0]    exp_t [16];
    logic [EW-1:0] exp_in;

    always #5 clk = ~clk;

    training_data_server dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .load_we            (load_we),
        .load_addr          (load_addr),
        .load_data          (load_data),
        .load_type          (load_type),
        .load_input_we      (load_input_we),
        .start              (start),
        .data_request       (data_request),
        .training_data      (training_data),
        .training_data_type (training_data_type),
        .input_data         (input_data),
        .read_done          (read_done),
        .elem_index         (elem_index),
        .busy               (busy),
        .pass_done          (pass_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_elem(input int a, input logic [EW-1:0] d,
                             input logic [1:0] t);
        load_we   = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        load_type = t;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) begin
            $display("FAIL start_busy got=%b exp=1", busy);
        end else pass_cnt++;
    endtask

    task automatic serve_one(input int i);
        data_request = 1'b1;
        tick();
        total_cnt++;
        if (read_done !== 1'b0) begin
            $display("FAIL early_rd[%0d] got=%b exp=0", i, read_done);
        end else pass_cnt++;
        tick();
        data_request = 1'b0;
        total_cnt++;
        if (read_done !== 1'b1 || elem_index !== 4'(i) ||
            training_data !== exp_d[i] ||
            training_data_type !== exp_t[i]) begin
            $display("FAIL serve[%0d] rd=%b idx=%0d data=%h type=%0d exp idx=%0d data=%h type=%0d",
                     i, read_done, elem_index, training_data,
                     training_data_type, i, exp_d[i], exp_t[i]);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (read_done !== 1'b0 || pass_done !== (i == 15) ||
            busy !== (i != 15)) begin
            $display("FAIL after[%0d] rd=%b pd=%b busy=%b exp rd=0 pd=%b busy=%b",
                     i, read_done, pass_done, busy, i == 15, i != 15);
        end else pass_cnt++;
        tick();
        if (i == 15) begin
            total_cnt++;
            if (pass_done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL pd_pulse pd=%b busy=%b exp 0 0",
                         pass_done, busy);
            end else pass_cnt++;
        end
    endtask

    task automatic run_pass();
        do_start();
        for (int i = 0; i < 16; i++) serve_one(i);
    endtask

    task automatic test_reset();
        int rd_seen;
        rst_n = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (training_data !== '0 || training_data_type !== '0 ||
            input_data !== '0 || read_done !== 1'b0 ||
            elem_index !== '0 || busy !== 1'b0 || pass_done !== 1'b0) begin
            $display("FAIL reset_outs data=%h type=%0d in=%h rd=%b idx=%0d busy=%b pd=%b exp all 0",
                     training_data, training_data_type, input_data,
                     read_done, elem_index, busy, pass_done);
        end else pass_cnt++;
        rst_n = 1'b1;
        tick();
        rd_seen = 0;
        for (int k = 0; k < 3; k++) begin
            data_request = 1'b1;
            tick();
            rd_seen += int'(read_done);
            data_request = 1'b0;
            tick();
            rd_seen += int'(read_done);
            tick();
            rd_seen += int'(read_done);
        end
        total_cnt++;
        if (rd_seen != 0 || busy !== 1'b0) begin
            $display("FAIL idle_req rd_count=%0d busy=%b exp 0 0",
                     rd_seen, busy);
        end else pass_cnt++;
    endtask

    task automatic test_full_pass();
        for (int i = 0; i < 16; i++) begin
            exp_d[i] = EW'(i);
            exp_t[i] = 2'(i % 4);
            load_elem(i, exp_d[i], exp_t[i]);
        end
        run_pass();
        repeat (3) tick();
        total_cnt++;
        if (training_data !== exp_d[15] || training_data_type !== exp_t[15]) begin
            $display("FAIL hold_after_pass data=%h type=%0d exp %h %0d",
                     training_data, training_data_type, exp_d[15], exp_t[15]);
        end else pass_cnt++;
    endtask

    task automatic test_level_held();
        int rd_seen;
        do_start();
        rd_seen = 0;
        data_request = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            rd_seen += int'(read_done);
        end
        data_request = 1'b0;
        tick();
        rd_seen += int'(read_done);
        tick();
        total_cnt++;
        if (rd_seen != 1 || elem_index !== 4'd0 ||
            training_data !== exp_d[0]) begin
            $display("FAIL level_held rd_count=%0d idx=%0d exp 1 0",
                     rd_seen, elem_index);
        end else pass_cnt++;
        for (int i = 1; i < 16; i++) serve_one(i);
    endtask

    task automatic test_blocked_load();
        do_start();
        load_elem(3, EW'(8'hAA), 2'd1);
        tick();
        for (int i = 0; i < 16; i++) serve_one(i);
        load_elem(3, EW'(8'hAA), 2'd1);
        exp_d[3] = EW'(8'hAA);
        exp_t[3] = 2'd1;
        tick();
        run_pass();
    endtask

    task automatic test_midpass_reset();
        do_start();
        for (int i = 0; i < 5; i++) serve_one(i);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (training_data !== '0 || elem_index !== '0 ||
            busy !== 1'b0 || read_done !== 1'b0 ||
            training_data_type !== '0) begin
            $display("FAIL midpass_reset data=%h idx=%0d busy=%b exp 0",
                     training_data, elem_index, busy);
        end else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (read_done !== 1'b0 || pass_done !== 1'b0) begin
            $display("FAIL abort_pulses rd=%b pd=%b exp 0 0",
                     read_done, pass_done);
        end else pass_cnt++;
        do_start();
        serve_one(0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_input_reg();
        exp_in = {16{8'h55}};
        load_data = exp_in;
        load_input_we = 1'b1;
        tick();
        load_input_we = 1'b0;
        load_data = '0;
        total_cnt++;
        if (input_data !== exp_in) begin
            $display("FAIL input_load got=%h exp=%h", input_data, exp_in);
        end else pass_cnt++;
        for (int p = 0; p < 2; p++) begin
            do_start();
            load_data = '1;
            load_input_we = 1'b1;
            tick();
            load_input_we = 1'b0;
            load_data = '0;
            for (int i = 0; i < 16; i++) serve_one(i);
            total_cnt++;
            if (input_data !== exp_in) begin
                $display("FAIL input_hold[%0d] got=%h exp=%h",
                         p, input_data, exp_in);
            end else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_level_held();
        test_blocked_load();
        test_midpass_reset();
        test_input_reg();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
